// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing one vga_adapter pixel port among NREQ drawing engines.
// Optional off-screen clipping is enabled by defining VGA_DRAW_ARBITER_CLIP_EN.
module vga_draw_arbiter #(
   parameter int NREQ  = 3,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      eng_start,
   input  logic [NREQ-1:0]      eng_done,
   input  logic [8*NREQ-1:0]    eng_x,
   input  logic [7*NREQ-1:0]    eng_y,
   input  logic [3*NREQ-1:0]    eng_colour,
   input  logic [NREQ-1:0]      eng_plot,
   output logic [7:0]           vga_x,
   output logic [6:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 vga_plot,
   output logic                 busy,
   output logic [1:0]           gnt_id,
   output logic [CNT_W-1:0]     plot_count,
   output logic [CNT_W-1:0]     clip_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]  state;
   logic [1:0]  ptr;
   logic [1:0]  next_gnt;
   logic        any_req;
   logic [7:0]  sel_x, last_x;
   logic [6:0]  sel_y, last_y;
   logic [2:0]  sel_colour, last_colour;
   logic        sel_plot, sel_done;
   logic        clip_hit;
   logic        fwd;

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
      logic [NREQ-1:0] v;
      v = '0;
      for (int i = 0; i < NREQ; i++) v[i] = (id == 2'(i));
      return v;
   endfunction

   // Pick the set request with the smallest rotational distance from the pointer.
   always_comb begin
      int best;
      int d;
      any_req  = 1'b0;
      next_gnt = 2'd0;
      best     = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         d = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
         if (req[i] && d < best) begin
            best     = d;
            any_req  = 1'b1;
            next_gnt = 2'(i);
         end
      end
   end

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_plot   = 1'b0;
      sel_done   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_id == 2'(i)) begin
            sel_x      = eng_x[8*i +: 8];
            sel_y      = eng_y[7*i +: 7];
            sel_colour = eng_colour[3*i +: 3];
            sel_plot   = eng_plot[i];
            sel_done   = eng_done[i];
         end
      end
   end

`ifdef VGA_DRAW_ARBITER_CLIP_EN
   assign clip_hit = (sel_x >= 8'd160) || (sel_y >= 7'd120);
`else
   assign clip_hit = 1'b0;
`endif

   assign fwd        = (state == S_RUN) && sel_plot && !clip_hit;
   assign vga_plot   = fwd;
   assign vga_x      = (state == S_RUN) ? sel_x      : last_x;
   assign vga_y      = (state == S_RUN) ? sel_y      : last_y;
   assign vga_colour = (state == S_RUN) ? sel_colour : last_colour;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ptr         <= 2'd0;
         gnt_id      <= 2'd0;
         eng_start   <= '0;
         ack         <= '0;
         busy        <= 1'b0;
         plot_count  <= '0;
         last_x      <= '0;
         last_y      <= '0;
         last_colour <= '0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  gnt_id     <= next_gnt;
                  plot_count <= '0;
                  state      <= S_GRANT;
               end
            end
            S_GRANT: begin
               eng_start <= onehot(gnt_id);
               busy      <= 1'b1;
               state     <= S_RUN;
            end
            S_RUN: begin
               last_x      <= sel_x;
               last_y      <= sel_y;
               last_colour <= sel_colour;
               if (fwd && plot_count != {CNT_W{1'b1}})
                  plot_count <= plot_count + 1'b1;
               if (sel_done) begin
                  eng_start <= '0;
                  ack       <= onehot(gnt_id);
                  state     <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               // Wait until the engine has observed start low before re-arbitrating.
               if (!sel_done) begin
                  ptr   <= (gnt_id == 2'(NREQ-1)) ? 2'd0 : gnt_id + 2'd1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef VGA_DRAW_ARBITER_CLIP_EN
   logic [CNT_W-1:0] clip_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         clip_q <= '0;
      else if (state == S_IDLE && any_req)
         clip_q <= '0;
      else if (state == S_RUN && sel_plot && clip_hit && clip_q != {CNT_W{1'b1}})
         clip_q <= clip_q + 1'b1;
   end

   assign clip_count = clip_q;
`else
   assign clip_count = '0;
`endif

endmodule
